data_cache_responder: RTL and testbench
=======================================

DATA_CACHE_RESPONDER -- requirements
Module: data_cache_responder

Parameters
REQ-001 The block SHALL have parameter NUM_LINES, default 16, meaning direct-mapped line count (power of two).
REQ-002 The block SHALL have parameter WORDS_PER_LINE, default 4, meaning 32-bit words per line (power of two).

Interface
REQ-003 The block SHALL have port Clk  input  1  meaning the single clock; all state changes on posedge.
REQ-004 The block SHALL have port Rst_n  input  1  meaning the asynchronous, active-low reset.
REQ-005 The block SHALL have port address  input  32  meaning the pipeline byte address; bits [1:0] are ignored.
REQ-006 The block SHALL have port data  input  32  meaning the pipeline store data.
REQ-007 The block SHALL have port dataRead  input  1  meaning the pipeline load request.
REQ-008 The block SHALL have port dataWrite  input  1  meaning the pipeline store request.
REQ-009 The block SHALL have port outData  output  32  meaning the load data, valid while hit=1 and dataRead=1.
REQ-010 The block SHALL have port hit  output  1  meaning the request is complete; 0 stalls the pipeline.
REQ-011 The block SHALL have port memReq  output  1  meaning a backing-memory word request.
REQ-012 The block SHALL have port memWe  output  1  meaning the memReq is a write.
REQ-013 The block SHALL have port memAddr  output  32  meaning the word-aligned backing address.
REQ-014 The block SHALL have port memWData  output  32  meaning the backing write data.
REQ-015 The block SHALL have port memRData  input  32  meaning the backing read data, valid with memAck.
REQ-016 The block SHALL have port memAck  input  1  meaning backing-memory completion, one cycle per word.

Function
REQ-017 Address split SHALL be: word = [3:2], index = [7:4], tag = [31:8] (defaults; widths derive from parameters).
REQ-018 Each line SHALL hold valid, dirty, tag and WORDS_PER_LINE data words; the policy is write-back, write-allocate.
REQ-019 FSM states SHALL be IDLE, WRITEBACK, FILL and DONE.
REQ-020 In IDLE with no request, hit SHALL be 1.
REQ-021 In IDLE with a request where valid=1 and tag matches, hit SHALL be 1 combinationally (0-cycle latency) and outData SHALL be the addressed word.
REQ-022 A write hit SHALL update the word and set dirty at the next posedge.
REQ-023 When dataRead and dataWrite are both 1, the block SHALL perform the write; outData SHALL show the pre-write word.
REQ-024 On a miss in IDLE, hit SHALL be 0; the block SHALL latch address, data and operation; the next state SHALL be WRITEBACK if the victim is valid and dirty, else FILL.
REQ-025 WRITEBACK SHALL issue WORDS_PER_LINE write handshakes, word 0 first, to {victim tag, index, word, 00}, then go to FILL.
REQ-026 FILL SHALL issue WORDS_PER_LINE read handshakes to {latched tag, index, word, 00}, storing memRData on each memAck.
REQ-027 After the last fill word, the block SHALL set valid=1, set dirty=0 and write the tag, then go to DONE.
REQ-028 In DONE, the block SHALL apply a latched write (dirty=1), drive hit=1 and drive outData from the line, then return to IDLE.
REQ-029 Miss latency SHALL be clean: N fill acks + 1 cycle; dirty: N writeback acks + N fill acks + 1 cycle.
REQ-030 memReq, memWe, memAddr and memWData SHALL hold stable from assertion until the posedge sampling memAck=1.
REQ-031 memReq SHALL deassert for at least 0 cycles between words; back-to-back requests are allowed.
REQ-032 memAck while memReq=0 SHALL be ignored.
REQ-033 Pipeline inputs changing while hit=0 SHALL be ignored; the latched request governs the transaction.
REQ-034 hit SHALL be 0 in WRITEBACK and FILL regardless of inputs.

Reset
REQ-035 Rst_n=0 SHALL asynchronously clear all valid and dirty bits, set the state to IDLE, and drive memReq=0, memWe=0, memAddr=0 and memWData=0.
REQ-036 Reset mid-WRITEBACK or mid-FILL SHALL abort with no line marked valid and memReq low immediately.
REQ-037 Data and tag arrays SHALL NOT require reset.

Structure
REQ-038 The FSM state encoding and address-field width constants SHALL live in shared package cache_pkg.
REQ-039 Storage SHALL be one sub-module, cache_line_array, holding the tag/valid/dirty/data arrays with an asynchronous read and a synchronous write.

Verification
REQ-040 Reset, then read 0x00000010 with memRData=0xAAAA000n on word n -> hit=0 for 4 acks + 1 cycle, then outData=0xAAAA0000 and memAddr sequence 0x10, 0x14, 0x18, 0x1C.
REQ-041 Then read 0x00000018 -> hit=1 the same cycle, outData=0xAAAA0002, memReq stays 0.
REQ-042 Write 0xDEADBEEF to 0x00000014, then read 0x00000114 (same index) -> writeback of 4 words with memWe=1, including 0xDEADBEEF at 0x14, then fill from 0x110.
REQ-043 dataRead=dataWrite=1 on a hit at 0x18 with data 0x12345678 -> outData is the old word; next read returns 0x12345678.
REQ-044 Hold memAck=0 for 5 cycles mid-FILL -> memReq and memAddr remain stable and hit=0 throughout.
REQ-045 Assert Rst_n=0 after the 2nd fill ack -> memReq=0 immediately; after release, a read of the same address misses again.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: FSM encoding and address-field widths shared
// by the direct-mapped data cache responder and its storage.
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_FILL,
    S_DONE
  } state_e;

  localparam int OFF_W      = 2;
  localparam int DEF_WORD_W = 2;
  localparam int DEF_IDX_W  = 4;

  function automatic int tag_width(int lines, int words);
    return 32 - $clog2(lines) - $clog2(words) - OFF_W;
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: valid/dirty/tag/data storage for all lines,
// one shared index, asynchronous read and synchronous write.
module cache_line_array #(
  parameter int NUM_LINES = 16,
  parameter int WORDS     = 4,
  parameter int TAG_W     = 24
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [$clog2(NUM_LINES)-1:0] idx_i,
  output logic                         valid_o,
  output logic                         dirty_o,
  output logic [TAG_W-1:0]             tag_o,
  output logic [WORDS-1:0][31:0]       line_o,
  input  logic                         wr_en_i,
  input  logic [$clog2(WORDS)-1:0]     wr_word_i,
  input  logic [31:0]                  wr_data_i,
  input  logic                         fill_done_i,
  input  logic [TAG_W-1:0]             fill_tag_i,
  input  logic                         dirty_set_i
);

  logic [NUM_LINES-1:0]   valid_q;
  logic [NUM_LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [WORDS-1:0][31:0] data_q [NUM_LINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

  // Line state bits: cleared by reset, set by fill or store
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_done_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (dirty_set_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data words carry no reset; valid guards them
  always_ff @(posedge clk_i) begin
    if (fill_done_i) tag_q[idx_i] <= fill_tag_i;
    if (wr_en_i) data_q[idx_i][wr_word_i] <= wr_data_i;
  end

endmodule

// File: rtl/data_cache_responder.sv
// data_cache_responder: write-back, write-allocate direct-mapped
// data cache with 0-cycle hits and word-serial line refill.
module data_cache_responder
  import cache_pkg::*;
#(
  parameter int NUM_LINES      = 1 << DEF_IDX_W,
  parameter int WORDS_PER_LINE = 1 << DEF_WORD_W
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] address,
  input  logic [31:0] data,
  input  logic        dataRead,
  input  logic        dataWrite,
  output logic [31:0] outData,
  output logic        hit,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  input  logic        memAck
);

  localparam int WORD_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int TAG_LSB = OFF_W + WORD_W + IDX_W;
  localparam int TAG_W   = tag_width(NUM_LINES, WORDS_PER_LINE);
  localparam logic [WORD_W-1:0] LAST =
    WORD_W'(WORDS_PER_LINE - 1);

  state_e                state_q, state_d;
  logic [31:OFF_W]       addr_q, addr_d;
  logic [31:0]           wdat_q, wdat_d;
  logic                  wr_q, wr_d;
  logic [WORD_W-1:0]     cnt_q, cnt_d;

  logic [31:OFF_W]       cur;
  logic [IDX_W-1:0]      idx;
  logic [WORD_W-1:0]     word;
  logic [TAG_W-1:0]      tag;

  logic                  rd_valid, rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  logic [WORDS_PER_LINE-1:0][31:0] rd_line;

  logic                  wr_en, fill_done, dirty_set;
  logic [WORD_W-1:0]     wr_word;
  logic [31:0]           wr_data;
  logic                  req, line_hit;
  logic                  unused_addr;

  // Once a miss is taken the latched request owns the index
  assign cur  = (state_q == S_IDLE) ? address[31:OFF_W] : addr_q;
  assign idx  = cur[TAG_LSB-1:OFF_W+WORD_W];
  assign word = cur[OFF_W+WORD_W-1:OFF_W];
  assign tag  = cur[31:TAG_LSB];

  assign req         = dataRead | dataWrite;
  assign line_hit    = rd_valid && (rd_tag == tag);
  assign outData     = rd_line[word];
  assign unused_addr = ^address[OFF_W-1:0];

  cache_line_array #(
    .NUM_LINES (NUM_LINES),
    .WORDS     (WORDS_PER_LINE),
    .TAG_W     (TAG_W)
  ) u_lines (
    .clk_i       (Clk),
    .rst_ni      (Rst_n),
    .idx_i       (idx),
    .valid_o     (rd_valid),
    .dirty_o     (rd_dirty),
    .tag_o       (rd_tag),
    .line_o      (rd_line),
    .wr_en_i     (wr_en),
    .wr_word_i   (wr_word),
    .wr_data_i   (wr_data),
    .fill_done_i (fill_done),
    .fill_tag_i  (tag),
    .dirty_set_i (dirty_set)
  );

  // State and latched miss request
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdat_q  <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, pipeline handshake and backing-memory requests
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    hit       = 1'b0;
    memReq    = 1'b0;
    memWe     = 1'b0;
    memAddr   = '0;
    memWData  = '0;
    wr_en     = 1'b0;
    wr_word   = word;
    wr_data   = data;
    fill_done = 1'b0;
    dirty_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!req) begin
          hit = 1'b1;
        end else if (line_hit) begin
          hit = 1'b1;
          if (dataWrite) begin
            wr_en     = 1'b1;
            dirty_set = 1'b1;
          end
        end else begin
          addr_d  = address[31:OFF_W];
          wdat_d  = data;
          wr_d    = dataWrite;
          cnt_d   = '0;
          state_d = (rd_valid && rd_dirty) ?
                    S_WRITEBACK : S_FILL;
        end
      end
      S_WRITEBACK: begin
        memReq   = 1'b1;
        memWe    = 1'b1;
        memAddr  = {rd_tag, idx, cnt_q, {OFF_W{1'b0}}};
        memWData = rd_line[cnt_q];
        if (memAck) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = S_FILL;
        end
      end
      S_FILL: begin
        memReq  = 1'b1;
        memAddr = {tag, idx, cnt_q, {OFF_W{1'b0}}};
        if (memAck) begin
          wr_en   = 1'b1;
          wr_word = cnt_q;
          wr_data = memRData;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            fill_done = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE: begin
        hit = 1'b1;
        if (wr_q) begin
          wr_en     = 1'b1;
          wr_data   = wdat_q;
          dirty_set = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_cache_responder.sv
// tb_data_cache_responder: vector table plus miss sequences,
// backing memory driven from an expected-transaction queue.
module tb_data_cache_responder;

  logic        Clk, Rst_n;
  logic [31:0] address, data, outData;
  logic        dataRead, dataWrite, hit;
  logic        memReq, memWe, memAck;
  logic [31:0] memAddr, memWData, memRData;

  data_cache_responder dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .address   (address),
    .data      (data),
    .dataRead  (dataRead),
    .dataWrite (dataWrite),
    .outData   (outData),
    .hit       (hit),
    .memReq    (memReq),
    .memWe     (memWe),
    .memAddr   (memAddr),
    .memWData  (memWData),
    .memRData  (memRData),
    .memAck    (memAck)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        rd;
    logic        wr;
    logic [31:0] exp;
  } vec_t;

  mem_t        q_exp[$];
  logic [31:0] q_out[$];
  logic [31:0] bmem[logic [31:0]];

  int n_tests = 0;
  int n_fail  = 0;
  int acks_total = 0;
  int stall_at = -1;
  int stall_rem = 0;
  bit pend = 1'b0;
  logic [31:0] hold_addr, hold_wdata;
  logic        hold_we;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a[31:8] == 24'h0) return 32'hAAAA0000 + 32'(a[3:2]);
    return {8'hC3, a[23:0]};
  endfunction

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_rd(logic [31:0] a);
    mem_t m;
    m.we = 1'b0; m.addr = a; m.wdata = '0;
    q_exp.push_back(m);
  endtask

  task automatic push_wr(logic [31:0] a, logic [31:0] d);
    mem_t m;
    m.we = 1'b1; m.addr = a; m.wdata = d;
    q_exp.push_back(m);
  endtask

  task automatic push_fill(logic [31:0] base);
    for (int w = 0; w < 4; w++) push_rd(base + 32'(4 * w));
  endtask

  // Backing memory: acks every request unless a stall is armed
  always @(negedge Clk) begin
    mem_t m;
    memAck = 1'b0;
    if (Rst_n && memReq) begin
      if (pend) begin
        check("mem hold addr", memAddr, hold_addr);
        check("mem hold we", 32'(memWe), 32'(hold_we));
        if (hold_we) check("mem hold wdata", memWData, hold_wdata);
      end
      hold_addr = memAddr;
      hold_we = memWe;
      hold_wdata = memWData;
      if (stall_rem > 0 && acks_total == stall_at) begin
        stall_rem--;
        pend = 1'b1;
        check("stall hit", 32'(hit), 32'd0);
      end else begin
        pend = 1'b0;
        if (q_exp.size() == 0) begin
          check("unexpected mem req", memAddr, 32'hFFFFFFFF);
        end else begin
          m = q_exp.pop_front();
          check("mem we", 32'(memWe), 32'(m.we));
          check("mem addr", memAddr, m.addr);
          if (m.we) check("mem wdata", memWData, m.wdata);
        end
        if (memWe) bmem[memAddr] = memWData;
        memRData = bmem.exists(memAddr) ? bmem[memAddr]
                                        : mem_word(memAddr);
        memAck = 1'b1;
        acks_total++;
      end
    end else begin
      pend = 1'b0;
    end
  end

  task automatic access(logic [31:0] a, logic [31:0] d,
                        logic rd, logic wr,
                        logic [31:0] exp_out, int exp_cyc);
    int cyc;
    logic [31:0] e;
    @(negedge Clk);
    address = a; data = d; dataRead = rd; dataWrite = wr;
    q_out.push_back(exp_out);
    cyc = 0;
    #1;
    while (!hit && cyc < 200) begin
      @(negedge Clk);
      #1;
      cyc++;
    end
    check("stall cycles", 32'(cyc), 32'(exp_cyc));
    e = q_out.pop_front();
    if (rd) check("outData", outData, e);
  endtask

  task automatic idle();
    @(negedge Clk);
    dataRead = 1'b0;
    dataWrite = 1'b0;
  endtask

  vec_t tbl[8];
  int   base;
  int   guard;

  initial begin
    memAck = 1'b0; memRData = '0;
    address = '0; data = '0; dataRead = 1'b0; dataWrite = 1'b0;
    Rst_n = 1'b0;
    #12;
    check("rst hit", 32'(hit), 32'd1);
    check("rst memReq", 32'(memReq), 32'd0);
    check("rst memWe", 32'(memWe), 32'd0);
    check("rst memAddr", memAddr, 32'd0);
    check("rst memWData", memWData, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    push_fill(32'h10);
    access(32'h10, 0, 1, 0, 32'hAAAA0000, 5);
    access(32'h18, 0, 1, 0, 32'hAAAA0002, 0);
    check("hit memReq", 32'(memReq), 32'd0);

    tbl[0] = '{32'h10, 0, 1, 0, 32'hAAAA0000};
    tbl[1] = '{32'h1C, 0, 1, 0, 32'hAAAA0003};
    tbl[2] = '{32'h17, 0, 1, 0, 32'hAAAA0001};
    tbl[3] = '{32'h1C, 32'h11112222, 0, 1, 0};
    tbl[4] = '{32'h1C, 0, 1, 0, 32'h11112222};
    tbl[5] = '{32'h18, 32'h12345678, 1, 1, 32'hAAAA0002};
    tbl[6] = '{32'h18, 0, 1, 0, 32'h12345678};
    tbl[7] = '{32'h14, 32'hDEADBEEF, 0, 1, 0};
    for (int i = 0; i < 8; i++)
      access(tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].wr,
             tbl[i].exp, 0);

    push_wr(32'h10, 32'hAAAA0000);
    push_wr(32'h14, 32'hDEADBEEF);
    push_wr(32'h18, 32'h12345678);
    push_wr(32'h1C, 32'h11112222);
    push_fill(32'h110);
    access(32'h114, 0, 1, 0, 32'hC3000114, 9);

    push_fill(32'h10);
    access(32'h14, 0, 1, 0, 32'hDEADBEEF, 5);
    access(32'h18, 0, 1, 0, 32'h12345678, 0);

    stall_at = acks_total + 2;
    stall_rem = 5;
    push_fill(32'h20);
    access(32'h20, 0, 1, 0, 32'hAAAA0000, 10);
    check("stall consumed", 32'(stall_rem), 32'd0);
    idle();

    base = acks_total;
    push_fill(32'h30);
    @(negedge Clk);
    address = 32'h30; dataRead = 1'b1;
    guard = 0;
    while (acks_total < base + 2 && guard < 50) begin
      @(negedge Clk);
      #1;
      guard++;
    end
    check("fill acks before reset", 32'(acks_total - base), 32'd2);
    @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    #1;
    check("abort memReq", 32'(memReq), 32'd0);
    check("abort memAddr", memAddr, 32'd0);
    check("pending fill words", 32'(q_exp.size()), 32'd2);
    q_exp.delete();
    dataRead = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    push_fill(32'h30);
    access(32'h30, 0, 1, 0, 32'hAAAA0000, 5);
    idle();
    @(negedge Clk);
    check("leftover mem txns", 32'(q_exp.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
